// File: rtl/my_mux_pkg.sv
// Shared definitions for the my_mux 2:1 multiplexer.
//   MY_MUX_DEFAULT_WIDTH : default data width of my_mux
//   mux2                 : 1-bit select helper; an unknown select merges a/b
package my_mux_pkg;

  localparam int unsigned MY_MUX_DEFAULT_WIDTH = 1;

  // The conditional operator with an X/Z condition keeps bits where a==b and
  // yields X elsewhere, which is exactly the merge behaviour we want.
  function automatic logic mux2(input logic a, input logic b, input logic sel);
    return sel ? b : a;
  endfunction

endpackage

// File: rtl/my_mux_cell.sv
// 1-bit combinational 2:1 mux.
//   a   : bit selected when sel=0
//   b   : bit selected when sel=1
//   sel : select
//   y_c : combinational result (no state, no latch)
module my_mux_cell
  import my_mux_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y_c
);

  assign y_c = mux2(a, b, sel);

endmodule

// File: rtl/my_mux.sv
// Parameterised 2:1 multiplexer with a combinational output and a registered
// copy carrying a valid flag.
//   clk, rst_n  : clock (rising edge) and async active-low reset, registered path only
//   a, b, sel   : data inputs and select (0 -> a, 1 -> b)
//   out         : combinational selected data, live during reset
//   out_q       : selected data registered one clock later, RESET_VAL in reset
//   out_q_valid : high once out_q holds a post-reset sample
module my_mux
  import my_mux_pkg::*;
#(
  parameter int unsigned       WIDTH     = MY_MUX_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] out_q,
  output logic             out_q_valid
);

  // One cell per bit so the unknown-select merge applies bit by bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    my_mux_cell u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .sel (sel),
      .y_c (out[i])
    );
  end

  // Registered copy: sampled every edge, no enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= RESET_VAL;
      out_q_valid <= 1'b0;
    end else begin
      out_q       <= out;
      out_q_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_my_mux.sv
// Directed self-checking bench for my_mux (WIDTH=1 and WIDTH=8 instances).
module tb_my_mux;

  logic       clk;
  logic       rst_n;

  logic       a1, b1, sel1, out1, out_q1, vld1;
  logic [7:0] a8, b8, out8, out_q8;
  logic       sel8, vld8;

  int n_cmp = 0;
  int n_err = 0;

  // Truth table indexed by {a,b,sel}.
  logic [7:0] tt = 8'b1101_1000;

  localparam logic [7:0] RV8 = 8'h5A;

  my_mux #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .out(out1), .a(a1), .b(b1), .sel(sel1),
    .out_q(out_q1), .out_q_valid(vld1)
  );

  my_mux #(.WIDTH(8), .RESET_VAL(RV8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .out(out8), .a(a8), .b(b8), .sel(sel8),
    .out_q(out_q8), .out_q_valid(vld8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; sel1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; sel8 = 1'b0;

    // WIDTH=1 truth table, all 8 combinations, clock toggling under reset
    for (int i = 0; i < 8; i++) begin
      {a1, b1, sel1} = 3'(i);
      #10;
      check($sformatf("tt_%0d", i), 64'(out1), 64'(tt[i]));
    end

    // Registered path held in reset across several edges
    check("rst_q8", 64'(out_q8), 64'(RV8));
    check("rst_v8", 64'(vld8), 64'(1'b0));
    check("rst_q1", 64'(out_q1), 64'(1'b0));
    check("rst_v1", 64'(vld1), 64'(1'b0));

    // WIDTH=8 combinational path, live during reset
    a8 = 8'hA5; b8 = 8'h3C; sel8 = 1'b0;
    #1 check("w8_sel0", 64'(out8), 64'(8'hA5));
    sel8 = 1'b1;
    #1 check("w8_sel1", 64'(out8), 64'(8'h3C));

    // Release reset between edges; first edge loads b
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; sel1 = 1'b0;
    rst_n = 1'b1;
    #1 check("rel_q8_hold", 64'(out_q8), 64'(RV8));
    @(posedge clk); #1;
    check("first_q8", 64'(out_q8), 64'(8'h3C));
    check("first_v8", 64'(vld8), 64'(1'b1));
    check("first_q1", 64'(out_q1), 64'(1'b1));
    check("first_v1", 64'(vld1), 64'(1'b1));

    // Latency: out moves now, out_q one edge later
    @(negedge clk);
    sel8 = 1'b0;
    #1;
    check("lat_out", 64'(out8), 64'(8'hA5));
    check("lat_q_old", 64'(out_q8), 64'(8'h3C));
    @(posedge clk); #1;
    check("lat_q_new", 64'(out_q8), 64'(8'hA5));

    // Simultaneous data and select change just before the edge
    @(negedge clk); #4;
    a8 = 8'h0F; b8 = 8'hF0; sel8 = 1'b1;
    @(posedge clk); #1;
    check("simul_q", 64'(out_q8), 64'(8'hF0));
    check("simul_out", 64'(out8), 64'(8'hF0));

    // Mid-operation reset: clears without an edge
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_q8", 64'(out_q8), 64'(RV8));
    check("mid_v8", 64'(vld8), 64'(1'b0));
    check("mid_q1", 64'(out_q1), 64'(1'b0));
    check("mid_out", 64'(out8), 64'(8'hF0));

    // Recover after reset with a fresh pattern
    b8 = 8'h81;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rec_q8", 64'(out_q8), 64'(8'h81));
    check("rec_v8", 64'(vld8), 64'(1'b1));

    // Unknown select: equal a/b bits pass through
    a1 = 1'b1; b1 = 1'b1; sel1 = 1'bx;
    #1 check("xsel_11", 64'(out1), 64'(1'b1));
    a1 = 1'b0; b1 = 1'b0;
    #1 check("xsel_00", 64'(out1), 64'(1'b0));
    a8 = 8'h6C; b8 = 8'h6C; sel8 = 1'bx;
    #1 check("xsel_w8", 64'(out8), 64'(8'h6C));
    sel1 = 1'b0; sel8 = 1'b0;

    #20;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/my_mux.md
Name: my_mux

Overview:
- Parameterised 2:1 multiplexer. It selects data input a when sel=0 and data input b when sel=1.
- The primary output out is purely combinational.
- A registered copy of the selection, out_q, is also provided for timing-closure users. It carries a valid flag and is cleared by an asynchronous active-low reset.
- Leaf datapath primitive, used wherever a two-way data choice is needed (n2t gate library level).

Parameters:
- WIDTH, default 1: bit width of a, b, out and out_q; legal range 1..64.
- RESET_VAL, default '0 (WIDTH bits): value loaded into out_q while reset is asserted.

Ports:
- clk, input, 1: single clock, rising-edge active; used only by the registered path.
- rst_n, input, 1: asynchronous, active-low reset; deassertion is synchronised externally.
- out, output, WIDTH: combinational selected data.
- a, input, WIDTH: data input selected when sel=0.
- b, input, WIDTH: data input selected when sel=1.
- sel, input, 1: select; 0 selects a, 1 selects b.
- out_q, output, WIDTH: registered selected data, latency 1 clk.
- out_q_valid, output, 1: high once out_q holds a post-reset sampled value.

Behaviour:
- Combinational path:
  - out = sel ? b : a, bitwise, zero clock latency.
  - Independent of clk and rst_n: out stays live and correct during reset.
- Full truth table for WIDTH=1, written as a b sel -> out:
  - 000->0, 010->0, 100->1, 110->1
  - 001->0, 011->1, 101->0, 111->1
- Unknown select (simulation only):
  - If sel is X or Z, each out bit equals a[i] where a[i]==b[i]; otherwise that bit is X.
  - No latch may be inferred.
- Registered path:
  - On every rising clk edge with rst_n=1: out_q <= (sel ? b : a) and out_q_valid <= 1.
  - While rst_n=0, asynchronously and immediately: out_q = RESET_VAL and out_q_valid = 0.
  - Reset asserted mid-operation clears both registers at once, with no clock needed.
  - After rst_n rises, the first clk edge loads out_q and sets out_q_valid.
  - Simultaneous change of sel and data just before an edge: out_q captures the mux of the values present at that edge.
  - No enable, no handshake, no backpressure: data is sampled every cycle.
- Width rules:
  - a, b, out and out_q are all exactly WIDTH bits.
  - No extension or truncation occurs inside the block.
- Reset values:
  - out_q = RESET_VAL, out_q_valid = 0.
  - out is not reset; it follows its inputs.

Decomposition:
- No shared package is required.
- RESET_VAL defaults to all zeros; a project-wide constant may override it through the parameter.
- One natural sub-module: my_mux_cell, a 1-bit combinational 2:1 mux with the same X-merge rule.
  - my_mux instantiates WIDTH copies in a generate loop for out.
  - my_mux adds a single always_ff block for out_q and out_q_valid.

Test Plan:
- WIDTH=1: apply all 8 (a,b,sel) combinations, each held 10 time units, then check out against the truth table above; for example a=1, b=0, sel=1 -> out=0.
- WIDTH=8: a=8'hA5, b=8'h3C; sel=0 -> out=8'hA5; sel=1 -> out=8'h3C, with no clock edge required.
- Reset: hold rst_n=0 with clk toggling -> out_q=RESET_VAL, out_q_valid=0, while out still tracks its inputs. Release rst_n; after the first edge with sel=1 and b=8'h3C -> out_q=8'h3C, out_q_valid=1.
- Latency: change sel between edges -> out_q updates exactly one rising edge later, while out updates immediately.
- Mid-operation reset: drop rst_n between clock edges -> out_q and out_q_valid clear at once, with no edge needed.
- X select: a=b=1, sel=X -> out=1; a=0, b=1, sel=X -> out=X.
